// File: rtl/ram_port_arbiter.sv
// Two-requester (CPU / IO) arbiter for a single synchronous-read RAM port.
// Round-robin with a bounded lock option; read data returns one cycle after the grant.
module ram_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic              io_lock,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    logic       last_io_reg, last_io_next;
    logic [7:0] lock_cnt_reg, lock_cnt_next;
    logic       cpu_tag_reg, io_tag_reg;
    logic       lock_force;

    // The lock owner is always the most recent winner: a grant to the other side clears the count.
    assign lock_force = (lock_cnt_reg != 8'd0) && (lock_cnt_reg < MAX_CNT);

    always_comb begin
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        if (rst_n) begin
            if (lock_force && last_io_reg && io_req) begin
                io_gnt = 1'b1;
            end else if (lock_force && !last_io_reg && cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (cpu_req && io_req) begin
                cpu_gnt = last_io_reg;
                io_gnt  = !last_io_reg;
            end else begin
                cpu_gnt = cpu_req;
                io_gnt  = io_req;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end else if (io_gnt) begin
            ram_addr  = io_addr;
            ram_wdata = io_wdata;
            ram_we    = io_we;
        end
    end

    always_comb begin
        last_io_next  = last_io_reg;
        lock_cnt_next = 8'd0;
        if (cpu_gnt) begin
            last_io_next = 1'b0;
            if (cpu_lock)
                lock_cnt_next = (lock_force && !last_io_reg) ? lock_cnt_reg + 8'd1 : 8'd1;
        end else if (io_gnt) begin
            last_io_next = 1'b1;
            if (io_lock)
                lock_cnt_next = (lock_force && last_io_reg) ? lock_cnt_reg + 8'd1 : 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_io_reg  <= 1'b1;
            lock_cnt_reg <= 8'd0;
            cpu_tag_reg  <= 1'b0;
            io_tag_reg   <= 1'b0;
        end else begin
            last_io_reg  <= last_io_next;
            lock_cnt_reg <= lock_cnt_next;
            cpu_tag_reg  <= cpu_gnt && !cpu_we;
            io_tag_reg   <= io_gnt && !io_we;
        end
    end

    assign cpu_rvalid = cpu_tag_reg;
    assign io_rvalid  = io_tag_reg;
    assign cpu_rdata  = ram_q;
    assign io_rdata   = ram_q;

endmodule
